// File: rtl/sext_arb_pkg.sv
// Shared types for the sign-extension arbiter: output-register FSM states
// and source identifiers reported on o_src.
package sext_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic SRC_REQ0 = 1'b0;
    localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Owns the last-grant pointer, which moves only
// when i_advance reports an accepted transfer.
// Ports: i_clk, i_rst (sync, active-high), i_valid[1:0], i_advance, o_grant[1:0].
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic last_q;
    logic last_d;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        o_grant = 2'b00;
        unique case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = last_q ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (i_advance) begin
            last_d = o_grant[1];
        end
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sign_ext_behavioral.sv
// Combinational two's-complement sign extension from IN_W to OUT_W bits.
// Ports: i_data[IN_W-1:0], o_data[OUT_W-1:0].
module sign_ext_behavioral #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data
);

    assign o_data = OUT_W'($signed(i_data));

endmodule

// File: rtl/sext_rr_arbiter.sv
// Round-robin share of one registered sign-extension stage between an N0-bit
// and an N1-bit immediate requester, with valid/ready on every side.
// Ports: i_clk, i_rst, i_req{0,1}_valid/_data, o_req{0,1}_ready,
//        o_valid, i_ready, o_data[M-1:0], o_src.
module sext_rr_arbiter
    import sext_arb_pkg::*;
#(
    parameter int N0 = 12,
    parameter int N1 = 20,
    parameter int M  = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    output logic          o_req0_ready,
    input  logic [N0-1:0] i_req0_data,
    input  logic          i_req1_valid,
    output logic          o_req1_ready,
    input  logic [N1-1:0] i_req1_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [M-1:0]  o_data,
    output logic          o_src
);

    if (N0 > M || N1 > M) begin : g_width_check
        $error("sext_rr_arbiter: N0 and N1 must not exceed M");
    end

    state_e       state_q;
    state_e       state_d;
    logic [M-1:0] data_q;
    logic [M-1:0] data_d;
    logic         src_q;
    logic         src_d;

    logic [1:0]   grant;
    logic         can_accept;
    logic         accept_ok;
    logic         load;
    logic [M-1:0] ext0;
    logic [M-1:0] ext1;

    rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   ({i_req1_valid, i_req0_valid}),
        .i_advance (load),
        .o_grant   (grant)
    );

    sign_ext_behavioral #(.IN_W(N0), .OUT_W(M)) u_ext0 (
        .i_data (i_req0_data),
        .o_data (ext0)
    );

    sign_ext_behavioral #(.IN_W(N1), .OUT_W(M)) u_ext1 (
        .i_data (i_req1_data),
        .o_data (ext1)
    );

    // Reset wins over any transfer, so no requester sees ready while it is held.
    assign can_accept   = (state_q == ST_EMPTY) | i_ready;
    assign accept_ok    = can_accept & ~i_rst;
    assign o_req0_ready = grant[0] & accept_ok;
    assign o_req1_ready = grant[1] & accept_ok;
    assign load         = o_req0_ready | o_req1_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= SRC_REQ0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (i_ready && !load) begin
                    state_d = ST_EMPTY;
                end
            end
        endcase
    end

    always_comb begin
        data_d = data_q;
        src_d  = src_q;
        if (load) begin
            data_d = grant[1] ? ext1 : ext0;
            src_d  = grant[1] ? SRC_REQ1 : SRC_REQ0;
        end
    end

    always_comb begin
        o_valid = (state_q == ST_FULL);
        o_data  = data_q;
        o_src   = src_q;
    end

endmodule

// File: tb/tb_sext_rr_arbiter.sv
// Directed and randomized checks of sext_rr_arbiter: reset, extension,
// alternation, stall, mid-transfer reset, and a scoreboarded random run.
module tb_sext_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        v0;
    logic        r0;
    logic [11:0] d0;
    logic        v1;
    logic        r1;
    logic [19:0] d1;
    logic        ov;
    logic        rdy;
    logic [31:0] od;
    logic        osrc;

    int n_vec;
    int n_err;

    sext_rr_arbiter #(.N0(12), .N1(20), .M(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (v0),
        .o_req0_ready (r0),
        .i_req0_data  (d0),
        .i_req1_valid (v1),
        .o_req1_ready (r1),
        .i_req1_data  (d1),
        .o_valid      (ov),
        .i_ready      (rdy),
        .o_data       (od),
        .o_src        (osrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        rdy = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
        d0 = 12'h123; d1 = 20'h00045;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", ov); end
        n_vec++; if (od !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", od); end
        n_vec++; if (osrc !== 1'b0) begin n_err++; $display("FAIL reset_src got %b want 0", osrc); end
        n_vec++; if ({r1, r0} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", {r1, r0}); end
        rst = 1'b0;
        #1;
        n_vec++; if ({r1, r0} !== 2'b01) begin n_err++; $display("FAIL first_tie got %b want 01", {r1, r0}); end
        v0 = 1'b0; v1 = 1'b0;
        #1;
        idle();
    endtask

    task automatic test_single();
        @(negedge clk);
        v0 = 1'b1; d0 = 12'h800; v1 = 1'b0; rdy = 1'b1;
        #1;
        n_vec++; if (r0 !== 1'b1) begin n_err++; $display("FAIL single0_ready got %b want 1", r0); end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b1; d1 = 20'h7FFFF;
        #1;
        n_vec++; if (ov !== 1'b1) begin n_err++; $display("FAIL single0_valid got %b want 1", ov); end
        n_vec++; if (od !== 32'hFFFFF800) begin n_err++; $display("FAIL single0_data got %h want FFFFF800", od); end
        n_vec++; if (osrc !== 1'b0) begin n_err++; $display("FAIL single0_src got %b want 0", osrc); end
        n_vec++; if (r1 !== 1'b1) begin n_err++; $display("FAIL single1_ready got %b want 1", r1); end
        @(negedge clk);
        v1 = 1'b0;
        #1;
        n_vec++; if (od !== 32'h0007FFFF) begin n_err++; $display("FAIL single1_data got %h want 0007FFFF", od); end
        n_vec++; if (osrc !== 1'b1) begin n_err++; $display("FAIL single1_src got %b want 1", osrc); end
        @(negedge clk);
        #1;
        n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", ov); end
    endtask

    task automatic test_alternate();
        logic [31:0] exp_d;
        logic        exp_s;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rdy = 1'b1;
            v0 = (i < 6); v1 = (i < 6);
            d0 = 12'hFFF; d1 = 20'h80000;
            #1;
            if (i < 6) begin
                exp_s = i[0];
                n_vec++;
                if ({r1, r0} !== (exp_s ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL alt_ready[%0d] got %b want src %b", i, {r1, r0}, exp_s);
                end
            end
            if (i > 0) begin
                exp_s = ~i[0];
                exp_d = exp_s ? 32'hFFF80000 : 32'hFFFFFFFF;
                n_vec++;
                if (osrc !== exp_s || od !== exp_d || ov !== 1'b1) begin
                    n_err++; $display("FAIL alt_out[%0d] got %b/%h want %b/%h", i, osrc, od, exp_s, exp_d);
                end
            end
        end
        idle();
    endtask

    task automatic test_stall();
        @(negedge clk);
        v0 = 1'b1; d0 = 12'h123; v1 = 1'b0; rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 12'h055; d1 = 20'h00001;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_vec++;
            if (ov !== 1'b1 || od !== 32'h00000123 || {r1, r0} !== 2'b00) begin
                n_err++; $display("FAIL stall[%0d] got v%b %h rdy%b want v1 00000123 rdy00", i, ov, od, {r1, r0});
            end
        end
        @(negedge clk);
        rdy = 1'b1;
        #1;
        n_vec++; if ({r1, r0} !== 2'b10) begin n_err++; $display("FAIL stall_resume got %b want 10", {r1, r0}); end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        #1;
        n_vec++;
        if (od !== 32'h00000001 || osrc !== 1'b1) begin
            n_err++; $display("FAIL stall_load got %b/%h want 1/00000001", osrc, od);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        v0 = 1'b1; d0 = 12'h321; v1 = 1'b0; rdy = 1'b1;
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b1; d1 = 20'h12345; rst = 1'b1;
        #1;
        n_vec++; if (ov !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b want 1", ov); end
        @(negedge clk);
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
        #1;
        n_vec++;
        if (ov !== 1'b0 || od !== 32'h0) begin
            n_err++; $display("FAIL rmid_drop got v%b %h want v0 00000000", ov, od);
        end
        n_vec++; if ({r1, r0} !== 2'b01) begin n_err++; $display("FAIL rmid_tie got %b want 01", {r1, r0}); end
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        #1;
        n_vec++;
        if (od !== 32'h00000321 || osrc !== 1'b0) begin
            n_err++; $display("FAIL rmid_load got %b/%h want 0/00000321", osrc, od);
        end
        idle();
    endtask

    task automatic test_random();
        logic [32:0] sb[$];
        logic [32:0] exp;
        logic        pv;
        logic        prdy;
        logic [31:0] pd;
        logic        ps;
        int          w0;
        int          w1;
        pv = 1'b0; prdy = 1'b1; pd = '0; ps = 1'b0; w0 = 0; w1 = 0;
        for (int c = 0; c < 10004; c++) begin
            @(negedge clk);
            if (c < 10000) begin
                v0 = ($urandom_range(0, 9) < 7);
                v1 = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 9) < 6);
            end else begin
                v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
            end
            d0 = 12'($urandom);
            d1 = 20'($urandom);
            #1;
            n_vec++;
            if ((r0 & r1) || (r0 & ~v0) || (r1 & ~v1)) begin
                n_err++; $display("FAIL rnd_ready[%0d] got r%b v%b", c, {r1, r0}, {v1, v0});
            end
            if ((~ov | rdy) && (v0 | v1)) begin
                n_vec++;
                if (!(r0 | r1)) begin n_err++; $display("FAIL rnd_live[%0d] got ready 00 want a grant", c); end
            end
            if (pv && !prdy) begin
                n_vec++;
                if (ov !== 1'b1 || od !== pd || osrc !== ps) begin
                    n_err++; $display("FAIL rnd_hold[%0d] got v%b %b/%h want v1 %b/%h", c, ov, osrc, od, ps, pd);
                end
            end
            n_vec++;
            if (ov !== (sb.size() != 0)) begin
                n_err++; $display("FAIL rnd_occ[%0d] got v%b want %0d queued", c, ov, sb.size());
            end
            if (ov && rdy && sb.size() != 0) begin
                exp = sb.pop_front();
                n_vec++;
                if ({osrc, od} !== exp) begin
                    n_err++; $display("FAIL rnd_data[%0d] got %b/%h want %b/%h", c, osrc, od, exp[32], exp[31:0]);
                end
            end
            if (r0 && v0) sb.push_back({1'b0, 32'($signed(d0))});
            if (r1 && v1) sb.push_back({1'b1, 32'($signed(d1))});
            if (!v0 || r0) w0 = 0;
            else if (r1) w0++;
            if (!v1 || r1) w1 = 0;
            else if (r0) w1++;
            if (w0 > 1 || w1 > 1) begin
                n_vec++; n_err++;
                $display("FAIL rnd_starve[%0d] got waits %0d/%0d want <= 1", c, w0, w1);
                w0 = 0; w1 = 0;
            end
            pv = ov; prdy = rdy; pd = od; ps = osrc;
        end
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL rnd_drain got %0d left want 0", sb.size()); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rdy = 1'b0; d0 = '0; d1 = '0;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
